// File: rtl/loader_pkg_rv32i.sv
// Shared definitions for the RV32I instruction-memory loader.
//   DEFAULT_ADDR_WIDTH : default word-address width of the instruction memory
//   state_e            : loader FSM state encoding
package loader_pkg_rv32i;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_e;

endpackage

// File: rtl/imem_loader_rv32i_if.sv
// Byte-stream, control/status and instruction-memory write bundle of the loader.
//   master : byte source / controller (drives start, word_count, rx_data, rx_valid)
//   slave  : the loader (drives rx_ready, imem_*, cpu_reset, busy, done, err)
interface imem_loader_rv32i_if #(
  parameter int unsigned ADDR_WIDTH = loader_pkg_rv32i::DEFAULT_ADDR_WIDTH
);

  logic                  start;
  logic [ADDR_WIDTH:0]   word_count;
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  imem_we;
  logic [31:0]           imem_waddr;
  logic [31:0]           imem_wdata;
  logic                  cpu_reset;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, word_count, rx_data, rx_valid,
    input  rx_ready, imem_we, imem_waddr, imem_wdata, cpu_reset, busy, done, err
  );

  modport slave (
    input  start, word_count, rx_data, rx_valid,
    output rx_ready, imem_we, imem_waddr, imem_wdata, cpu_reset, busy, done, err
  );

endinterface

// File: rtl/byte_packer_rv32i.sv
// Four-lane little-endian byte-to-word assembler.
//   clock, reset : clock and synchronous active-high reset
//   clr          : drop any partial word and restart at lane 0
//   byte_en      : accept byte_in into the current lane
//   byte_in      : stream byte
//   word_c       : word including the byte accepted this cycle
//   word_full_c  : strobe, this cycle's byte completes the word (lane 3)
module byte_packer_rv32i (
  input  logic        clock,
  input  logic        reset,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_c,
  output logic        word_full_c
);

  logic [3:0][7:0] lanes_q, lanes_d;
  logic [1:0]      byte_idx_q, byte_idx_d;

  // Lane fill; the 2-bit index wraps to lane 0 after lane 3.
  always_comb begin
    lanes_d    = lanes_q;
    byte_idx_d = byte_idx_q;
    if (clr) begin
      lanes_d    = '0;
      byte_idx_d = '0;
    end else if (byte_en) begin
      lanes_d[byte_idx_q] = byte_in;
      byte_idx_d          = byte_idx_q + 2'd1;
    end
  end

  // Look-ahead view so the owner can register the full word on the last byte.
  assign word_c      = lanes_d;
  assign word_full_c = byte_en && (byte_idx_q == 2'd3);

  always_ff @(posedge clock) begin
    if (reset) begin
      lanes_q    <= '0;
      byte_idx_q <= '0;
    end else begin
      lanes_q    <= lanes_d;
      byte_idx_q <= byte_idx_d;
    end
  end

endmodule

// File: rtl/imem_loader_rv32i.sv
// Loads the RV32I instruction memory from a byte stream, checks a trailing XOR
// checksum and holds the CPU in reset until a load completes cleanly.
//   clock, reset : clock and synchronous active-high reset
//   bus          : slave side of imem_loader_rv32i_if (start/word_count control,
//                  rx_* byte stream, imem_* word writes, cpu_reset/busy/done/err)
module imem_loader_rv32i
  import loader_pkg_rv32i::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input logic                clock,
  input logic                reset,
  imem_loader_rv32i_if.slave bus
);

  localparam int unsigned      CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << ADDR_WIDTH;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] word_idx_q, word_idx_d;
  logic [7:0]       csum_q, csum_d;
  logic             rx_ready_q, rx_ready_d;
  logic             imem_we_q, imem_we_d;
  logic [31:0]      imem_waddr_q, imem_waddr_d;
  logic [31:0]      imem_wdata_q, imem_wdata_d;
  logic             cpu_reset_q, cpu_reset_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             byte_fire_c;
  logic             pk_clr_c;
  logic             pk_en_c;
  logic             pk_full_c;
  logic [31:0]      pk_word_c;

  assign byte_fire_c = bus.rx_valid && rx_ready_q;
  assign pk_en_c     = byte_fire_c && (state_q == RECV);

  byte_packer_rv32i u_packer (
    .clock       (clock),
    .reset       (reset),
    .clr         (pk_clr_c),
    .byte_en     (pk_en_c),
    .byte_in     (bus.rx_data),
    .word_c      (pk_word_c),
    .word_full_c (pk_full_c)
  );

  // Next state, datapath updates and next values of the registered outputs.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    word_idx_d   = word_idx_q;
    csum_d       = csum_q;
    imem_wdata_d = imem_wdata_q;
    pk_clr_c     = 1'b0;

    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (bus.start) begin
          count_d    = bus.word_count;
          word_idx_d = '0;
          csum_d     = '0;
          pk_clr_c   = 1'b1;
          if (bus.word_count > DEPTH)          state_d = ERR;
          else if (bus.word_count == '0)       state_d = CHECK;
          else                                 state_d = RECV;
        end
      end
      RECV: begin
        if (byte_fire_c) begin
          csum_d = csum_q ^ bus.rx_data;
          if (pk_full_c) begin
            imem_wdata_d = pk_word_c;
            state_d      = WRITE;
          end
        end
      end
      WRITE: begin
        word_idx_d = word_idx_q + CNT_W'(1);
        state_d    = (word_idx_q + CNT_W'(1) == count_q) ? CHECK : RECV;
      end
      CHECK: begin
        if (byte_fire_c) state_d = (bus.rx_data == csum_q) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they align with it.
    rx_ready_d   = (state_d == RECV) || (state_d == CHECK);
    imem_we_d    = (state_d == WRITE);
    busy_d       = (state_d == RECV) || (state_d == WRITE) || (state_d == CHECK);
    done_d       = (state_d == DONE);
    err_d        = (state_d == ERR);
    cpu_reset_d  = (state_d != DONE);
    imem_waddr_d = BASE_ADDR + 32'({word_idx_d, 2'b00});
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q      <= '0;
      word_idx_q   <= '0;
      csum_q       <= '0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= BASE_ADDR;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      count_q      <= count_d;
      word_idx_q   <= word_idx_d;
      csum_q       <= csum_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_waddr_q <= imem_waddr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign bus.rx_ready   = rx_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_waddr = imem_waddr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign bus.cpu_reset  = cpu_reset_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_imem_loader_rv32i.sv
// Testbench for imem_loader_rv32i: directed vector table, reset/start corner
// sequences and randomized loads checked against a stream-level reference model.
`timescale 1ns/1ps
module tb_imem_loader_rv32i;

  localparam int unsigned AW     = 8;
  localparam int unsigned CW     = AW + 1;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int          DEPTH  = 1 << AW;
  localparam int          BUDGET = 3000;
  localparam int          NV     = 6;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];

  typedef struct packed {
    int               cnt;
    int               nbytes;
    logic [8:0][7:0]  bytes;
    int               mode;       // 0: valid always, 1: toggling, 2: random
    int               glitch;     // byte index at which to pulse start, -1 none
    bit               exp_done;
    int               exp_writes;
    logic [1:0][31:0] exp_data;
    int               exp_cycles; // -1: not checked
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  vec_t vecs[NV];

  imem_loader_rv32i_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader_rv32i #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory-side log of every write cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_addr.push_back(bus.imem_waddr);
      wr_data.push_back(bus.imem_wdata);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " rx_ready"},   32'(bus.rx_ready),  32'd0);
    check({tag, " imem_we"},    32'(bus.imem_we),   32'd0);
    check({tag, " imem_waddr"}, bus.imem_waddr,     BASE);
    check({tag, " imem_wdata"}, bus.imem_wdata,     32'd0);
    check({tag, " cpu_reset"},  32'(bus.cpu_reset), 32'd1);
    check({tag, " busy"},       32'(bus.busy),      32'd0);
    check({tag, " done"},       32'(bus.done),      32'd0);
    check({tag, " err"},        32'(bus.err),       32'd0);
  endtask

  // Reference model: cnt words of random data, little-endian byte order,
  // followed by the XOR of all payload bytes (corrupted when good==0).
  task automatic gen_load(input int cnt, input bit good, output bq_t s, output wq_t d);
    logic [7:0]  x;
    logic [31:0] w;
    s = {};
    d = {};
    x = 8'h00;
    if (cnt <= DEPTH) begin
      for (int k = 0; k < cnt; k++) begin
        w = $urandom;
        d.push_back(w);
        for (int b = 0; b < 4; b++) begin
          s.push_back(8'((w >> (8 * b)) & 32'hFF));
          x = x ^ 8'((w >> (8 * b)) & 32'hFF);
        end
      end
      s.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
    end
  endtask

  task automatic run_case(input string tag, input int cnt, input bq_t s, input int mode,
                          input int glitch, input bit exp_done, input wq_t exp_d,
                          input int exp_cycles);
    int cycles;
    int idx;
    int exp_consumed;
    bit glitched;
    bit fire;
    bit v;
    bit timed_out;
    exp_consumed = (cnt > DEPTH) ? 0 : 4 * cnt + 1;
    wr_addr.delete();
    wr_data.delete();
    bus.start      = 1'b1;
    bus.word_count = CW'(cnt);
    bus.rx_valid   = 1'b0;
    step();
    bus.start = 1'b0;
    cycles    = 1;
    idx       = 0;
    glitched  = 1'b0;
    v         = 1'b0;
    timed_out = 1'b0;
    if (cnt <= DEPTH) begin
      check({tag, " busy after start"},     32'(bus.busy),     32'd1);
      check({tag, " rx_ready after start"}, 32'(bus.rx_ready), 32'd1);
      check({tag, " done cleared"},         32'(bus.done),     32'd0);
      check({tag, " err cleared"},          32'(bus.err),      32'd0);
    end else begin
      check({tag, " err next cycle"},       32'(bus.err),      32'd1);
      check({tag, " rx_ready never"},       32'(bus.rx_ready), 32'd0);
    end
    while (!(bus.done === 1'b1 || bus.err === 1'b1)) begin
      if (cycles >= BUDGET) begin
        timed_out = 1'b1;
        break;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = ~v;
        default: v = bit'($urandom_range(0, 1));
      endcase
      bus.rx_valid = v && (idx < s.size());
      bus.rx_data  = (idx < s.size()) ? s[idx] : 8'h00;
      if (glitch == idx && !glitched) begin
        bus.start      = 1'b1;
        bus.word_count = CW'(5);
        glitched       = 1'b1;
      end
      fire = bus.rx_valid && bus.rx_ready;
      step();
      bus.start = 1'b0;
      cycles++;
      if (fire) idx++;
    end
    bus.rx_valid = 1'b0;
    check({tag, " timeout"},        32'(timed_out),     32'd0);
    check({tag, " done"},           32'(bus.done),      32'(exp_done));
    check({tag, " err"},            32'(bus.err),       32'(!exp_done));
    check({tag, " cpu_reset"},      32'(bus.cpu_reset), 32'(!exp_done));
    check({tag, " busy at end"},    32'(bus.busy),      32'd0);
    check({tag, " rx_ready at end"},32'(bus.rx_ready),  32'd0);
    check({tag, " bytes consumed"}, 32'(idx),           32'(exp_consumed));
    if (exp_cycles >= 0) check({tag, " cycles to result"}, 32'(cycles), 32'(exp_cycles));
    check({tag, " write count"},    32'(wr_data.size()), 32'(exp_d.size()));
    for (int k = 0; k < exp_d.size() && k < wr_data.size(); k++) begin
      check($sformatf("%s waddr[%0d]", tag, k), wr_addr[k], BASE + 32'(4 * k));
      check($sformatf("%s wdata[%0d]", tag, k), wr_data[k], exp_d[k]);
    end
  endtask

  function automatic vec_t base_vec(input logic [7:0] cs);
    vec_t v;
    v = '0;
    v.cnt         = 2;
    v.nbytes      = 9;
    v.bytes[0]    = 8'h13;
    v.bytes[1]    = 8'h00;
    v.bytes[2]    = 8'h00;
    v.bytes[3]    = 8'h00;
    v.bytes[4]    = 8'h93;
    v.bytes[5]    = 8'h00;
    v.bytes[6]    = 8'h10;
    v.bytes[7]    = 8'h00;
    v.bytes[8]    = cs;
    v.mode        = 0;
    v.glitch      = -1;
    v.exp_done    = 1'b1;
    v.exp_writes  = 2;
    v.exp_data[0] = 32'h0000_0013;
    v.exp_data[1] = 32'h0010_0093;
    v.exp_cycles  = 12;
    return v;
  endfunction

  initial begin
    bq_t s;
    wq_t d;
    bq_t s0;
    int  n;
    int  cyc;
    bit  fire;
    n_cmp = 0;
    n_bad = 0;

    // Directed vectors.
    vecs[0] = base_vec(8'h90);
    vecs[1] = base_vec(8'h91);
    vecs[1].exp_done = 1'b0;
    vecs[2] = '0;
    vecs[2].cnt = 0;  vecs[2].nbytes = 1; vecs[2].bytes[0] = 8'h00;
    vecs[2].glitch = -1; vecs[2].exp_done = 1'b1; vecs[2].exp_cycles = 2;
    vecs[3] = '0;
    vecs[3].cnt = DEPTH + 1; vecs[3].nbytes = 0;
    vecs[3].glitch = -1; vecs[3].exp_done = 1'b0; vecs[3].exp_cycles = 1;
    vecs[4] = base_vec(8'h13);
    vecs[4].cnt = 1; vecs[4].nbytes = 5; vecs[4].bytes[4] = 8'h13;
    vecs[4].mode = 1; vecs[4].exp_writes = 1; vecs[4].exp_cycles = -1;
    vecs[5] = base_vec(8'h90);
    vecs[5].glitch = 2;

    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.word_count = '0;
    bus.rx_data    = 8'h00;
    bus.rx_valid   = 1'b0;
    repeat (3) step();
    check_reset("por");
    rst = 1'b0;
    step();

    for (int i = 0; i < NV; i++) begin
      s = {};
      d = {};
      for (int b = 0; b < vecs[i].nbytes; b++) s.push_back(vecs[i].bytes[b]);
      for (int w = 0; w < vecs[i].exp_writes; w++) d.push_back(vecs[i].exp_data[w]);
      run_case($sformatf("vec%0d", i), vecs[i].cnt, s, vecs[i].mode, vecs[i].glitch,
               vecs[i].exp_done, d, vecs[i].exp_cycles);
    end

    // Reset in the middle of the second word of a 2-word load.
    s0 = {};
    vecs[0] = base_vec(8'h90);
    for (int b = 0; b < 9; b++) s0.push_back(vecs[0].bytes[b]);
    wr_addr.delete();
    wr_data.delete();
    bus.start      = 1'b1;
    bus.word_count = CW'(2);
    step();
    bus.start = 1'b0;
    n   = 0;
    cyc = 0;
    while (n < 6 && cyc < 100) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = s0[n];
      fire         = bus.rx_ready;
      step();
      cyc++;
      if (fire) n++;
    end
    bus.rx_valid = 1'b0;
    check("midrst bytes fed", 32'(n), 32'd6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset("midrst");
    check("midrst write count", 32'(wr_data.size()), 32'd1);
    if (wr_data.size() > 0) check("midrst wdata[0]", wr_data[0], 32'h0000_0013);
    d = {};
    d.push_back(32'h0000_0013);
    d.push_back(32'h0010_0093);
    run_case("reload", 2, s0, 0, -1, 1'b1, d, 12);

    // Largest legal count fills the whole memory.
    gen_load(DEPTH, 1'b1, s, d);
    run_case("full_depth", DEPTH, s, 0, -1, 1'b1, d, 2 + 5 * DEPTH);

    // Randomized loads against the reference model.
    for (int r = 0; r < 16; r++) begin
      int sel;
      int cnt;
      int mode;
      bit good;
      sel  = $urandom_range(0, 9);
      cnt  = (sel == 9) ? (DEPTH + 1 + $urandom_range(0, 200)) : $urandom_range(0, 5);
      good = ($urandom_range(0, 3) != 0);
      mode = (sel % 2 == 0) ? 0 : 2;
      gen_load(cnt, good, s, d);
      run_case($sformatf("rand%0d", r), cnt, s, mode, -1, good && (cnt <= DEPTH), d,
               (mode == 0) ? ((cnt > DEPTH) ? 1 : 2 + 5 * cnt) : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
